// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between the scan controller and its environment: enable, the
// update handshake with the incoming digit codes, and the mux/anode drive.
interface display_scan_ctrl_if;
    logic       en;
    logic       upd_req;
    logic [6:0] seg_in_a;
    logic [6:0] seg_in_b;
    logic [6:0] seg_in_c;
    logic [6:0] seg_in_d;
    logic [3:0] blank_in;
    logic       upd_ack;
    logic [6:0] mux_a;
    logic [6:0] mux_b;
    logic [6:0] mux_c;
    logic [6:0] mux_d;
    logic       s0;
    logic       s1;
    logic [3:0] an_n;
    logic       frame_start;

    modport master (
        output en, upd_req, seg_in_a, seg_in_b, seg_in_c, seg_in_d, blank_in,
        input  upd_ack, mux_a, mux_b, mux_c, mux_d, s0, s1, an_n, frame_start
    );

    modport slave (
        input  en, upd_req, seg_in_a, seg_in_b, seg_in_c, seg_in_d, blank_in,
        output upd_ack, mux_a, mux_b, mux_c, mux_d, s0, s1, an_n, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: slot timing with anode dead-time,
// mux select generation and frame-aligned shadow loading via req/ack.
module display_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int DEADTIME = 16
) (
    input  logic                clk,
    input  logic                rst,
    display_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic             pend_q, pend_d;
    logic [3:0]       blank_q, blank_d;
    logic [3:0]       an_n_q, an_n_d;
    logic             ack_q, ack_d;
    logic             fs_q, fs_d;
    logic [6:0]       mux_a_q, mux_b_q, mux_c_q, mux_d_q;
    logic             slot_end;
    logic             load;

    assign slot_end = (cnt_q == CNT_W'(PRESCALE - 1));

    // Outputs are registered from next-state values so the anodes, selects and
    // pulses all line up with the cycle in which the new slot/frame begins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        pend_d  = pend_q | bus.upd_req;
        load    = 1'b0;
        fs_d    = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            dig_d   = 2'd0;
            load    = (state_q == IDLE) && (pend_q || bus.upd_req);
        end else if (state_q == IDLE) begin
            // A request arriving with the rising enable waits for the next boundary.
            cnt_d = '0;
            dig_d = 2'd0;
            fs_d  = 1'b1;
        end else if (slot_end) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
            if (dig_q == 2'd3) begin
                fs_d = 1'b1;
                load = pend_q || bus.upd_req;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (bus.en) begin
            state_d = (cnt_d >= CNT_W'(DEADTIME)) ? ON : DEAD;
        end

        if (load) begin
            pend_d = 1'b0;
        end

        blank_d = load ? bus.blank_in : blank_q;
        ack_d   = load;

        an_n_d = 4'hF;
        if (state_d == ON && !blank_d[dig_d]) begin
            an_n_d[dig_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            pend_q  <= 1'b0;
            blank_q <= 4'b0000;
            an_n_q  <= 4'hF;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
            mux_a_q <= 7'h7F;
            mux_b_q <= 7'h7F;
            mux_c_q <= 7'h7F;
            mux_d_q <= 7'h7F;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            pend_q  <= pend_d;
            blank_q <= blank_d;
            an_n_q  <= an_n_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
            if (load) begin
                mux_a_q <= bus.seg_in_a;
                mux_b_q <= bus.seg_in_b;
                mux_c_q <= bus.seg_in_c;
                mux_d_q <= bus.seg_in_d;
            end
        end
    end

    assign bus.mux_a       = mux_a_q;
    assign bus.mux_b       = mux_b_q;
    assign bus.mux_c       = mux_c_q;
    assign bus.mux_d       = mux_d_q;
    assign bus.s0          = dig_q[0];
    assign bus.s1          = dig_q[1];
    assign bus.an_n        = an_n_q;
    assign bus.upd_ack     = ack_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl at PRESCALE=8, DEADTIME=2: scan timing,
// frame-aligned updates, blanking, idle updates, enable drop and reset.
module tb_display_scan_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(.PRESCALE(8), .DEADTIME(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps count cycles; c is the cycle index relative to a frame start.
    task automatic scanCheck(input int startCyc, input int count, input logic [3:0] blank);
        int c;
        int slot;
        logic [3:0] expAn;
        for (int i = 0; i < count; i++) begin
            tick();
            c = startCyc + i;
            slot = (c / 8) % 4;
            expAn = 4'hF;
            if ((c % 8) >= 2 && !blank[slot]) expAn[slot] = 1'b0;
            checkEq($sformatf("an_n c%0d", c), {28'd0, bus.an_n}, {28'd0, expAn});
            checkEq($sformatf("sel c%0d", c), {30'd0, bus.s1, bus.s0}, slot);
            checkEq($sformatf("fs c%0d", c), {31'd0, bus.frame_start}, {31'd0, (c % 32) == 0});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.upd_req = 1'b0;
        bus.seg_in_a = 7'h7F;
        bus.seg_in_b = 7'h7F;
        bus.seg_in_c = 7'h7F;
        bus.seg_in_d = 7'h7F;
        bus.blank_in = 4'b0000;
        tick();
        tick();

        // Reset state
        checkEq("rst an_n", {28'd0, bus.an_n}, 32'hF);
        checkEq("rst mux_a", {25'd0, bus.mux_a}, 32'h7F);
        checkEq("rst mux_d", {25'd0, bus.mux_d}, 32'h7F);
        checkEq("rst sel", {30'd0, bus.s1, bus.s0}, 32'd0);
        checkEq("rst ack", {31'd0, bus.upd_ack}, 32'd0);
        checkEq("rst fs", {31'd0, bus.frame_start}, 32'd0);

        rst = 1'b0;
        tick();
        bus.en = 1'b1;
        tick();
        checkEq("start fs c0", {31'd0, bus.frame_start}, 32'd1);
        checkEq("start an c0", {28'd0, bus.an_n}, 32'hF);

        // Scan frame 0 with a request pulsed during cycle 5
        scanCheck(1, 5, 4'b0000);
        bus.seg_in_a = 7'h40;
        bus.seg_in_c = 7'h79;
        bus.upd_req = 1'b1;
        scanCheck(6, 1, 4'b0000);
        bus.upd_req = 1'b0;
        checkEq("mux_a held c6", {25'd0, bus.mux_a}, 32'h7F);
        scanCheck(7, 25, 4'b0000);
        checkEq("mux_a held c31", {25'd0, bus.mux_a}, 32'h7F);
        checkEq("ack low c31", {31'd0, bus.upd_ack}, 32'd0);
        scanCheck(32, 1, 4'b0000);
        checkEq("ack c32", {31'd0, bus.upd_ack}, 32'd1);
        checkEq("mux_a c32", {25'd0, bus.mux_a}, 32'h40);
        checkEq("mux_c c32", {25'd0, bus.mux_c}, 32'h79);
        checkEq("mux_b c32", {25'd0, bus.mux_b}, 32'h7F);
        scanCheck(33, 1, 4'b0000);
        checkEq("ack pulse c33", {31'd0, bus.upd_ack}, 32'd0);

        // Blank digit 2; seg_in_d changes after the request and must be sampled late
        bus.blank_in = 4'b0100;
        bus.seg_in_b = 7'h24;
        bus.upd_req = 1'b1;
        scanCheck(34, 1, 4'b0000);
        bus.upd_req = 1'b0;
        bus.seg_in_d = 7'h30;
        scanCheck(35, 29, 4'b0000);
        scanCheck(64, 1, 4'b0100);
        checkEq("ack c64", {31'd0, bus.upd_ack}, 32'd1);
        checkEq("mux_b c64", {25'd0, bus.mux_b}, 32'h24);
        checkEq("mux_d c64", {25'd0, bus.mux_d}, 32'h30);
        scanCheck(65, 31, 4'b0100);
        scanCheck(96, 1, 4'b0100);
        checkEq("no ack c96", {31'd0, bus.upd_ack}, 32'd0);

        // Drop enable during ON of digit 1 (frame cycle 12)
        scanCheck(97, 12, 4'b0100);
        bus.en = 1'b0;
        tick();
        checkEq("endrop an", {28'd0, bus.an_n}, 32'hF);
        checkEq("endrop sel", {30'd0, bus.s1, bus.s0}, 32'd0);
        checkEq("endrop fs", {31'd0, bus.frame_start}, 32'd0);

        // Idle update loads on the next edge
        bus.seg_in_a = 7'h12;
        bus.blank_in = 4'b0000;
        bus.upd_req = 1'b1;
        tick();
        bus.upd_req = 1'b0;
        checkEq("idle ack", {31'd0, bus.upd_ack}, 32'd1);
        checkEq("idle mux_a", {25'd0, bus.mux_a}, 32'h12);
        checkEq("idle an", {28'd0, bus.an_n}, 32'hF);
        tick();
        tick();
        checkEq("idle ack pulse", {31'd0, bus.upd_ack}, 32'd0);
        checkEq("idle sel", {30'd0, bus.s1, bus.s0}, 32'd0);
        checkEq("idle an held", {28'd0, bus.an_n}, 32'hF);

        // Re-enable with a simultaneous request: it must wait for the boundary
        bus.en = 1'b1;
        bus.seg_in_a = 7'h55;
        bus.upd_req = 1'b1;
        tick();
        bus.upd_req = 1'b0;
        checkEq("reen fs", {31'd0, bus.frame_start}, 32'd1);
        checkEq("reen no ack", {31'd0, bus.upd_ack}, 32'd0);
        checkEq("reen mux_a", {25'd0, bus.mux_a}, 32'h12);
        scanCheck(1, 10, 4'b0000);

        // Reset with that request still pending drops it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkEq("rst2 an", {28'd0, bus.an_n}, 32'hF);
        checkEq("rst2 mux_a", {25'd0, bus.mux_a}, 32'h7F);
        checkEq("rst2 mux_b", {25'd0, bus.mux_b}, 32'h7F);
        checkEq("rst2 sel", {30'd0, bus.s1, bus.s0}, 32'd0);
        tick();
        checkEq("rst2 fs", {31'd0, bus.frame_start}, 32'd1);
        scanCheck(1, 31, 4'b0000);
        scanCheck(32, 1, 4'b0000);
        checkEq("rst2 no ack", {31'd0, bus.upd_ack}, 32'd0);
        checkEq("rst2 mux_a kept", {25'd0, bus.mux_a}, 32'h7F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the four-digit seven-segment display. It drives the select lines and the a/b/c/d data inputs of the downstream 7-bit 4:1 segment multiplexer. It also drives the active-low digit anodes, with dead-time between digits to prevent ghosting. New digit codes are taken through a req/ack handshake and applied only at frame boundaries, so the display never shows a torn frame.

## Interface

Parameters:
- PRESCALE, 50000, clock cycles per digit slot; legal range is DEADTIME+1 or more.
- DEADTIME, 16, cycles at the start of each slot with all anodes off; legal range is 1 to PRESCALE-1.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- upd_req  in  1  request to load seg_in_* and blank_in.
- seg_in_a, seg_in_b, seg_in_c, seg_in_d  in  7 each  segment codes for digits 0 to 3, active-low segments.
- blank_in  in  4  bit k=1 blanks digit k.
- upd_ack  out  1  one-cycle pulse when the shadow registers load.
- mux_a, mux_b, mux_c, mux_d  out  7 each  shadow segment codes, wired to mux inputs a/b/c/d.
- s0, s1  out  1 each  mux select; {s1,s0} = current digit index (00→a … 11→d).
- an_n  out  4  active-low anode enables, one-hot-low or all-high.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

## Operation

- All outputs are registered.
- Reset values:
  - s0=s1=0, an_n=4'b1111
  - mux_a..mux_d=7'h7F (all segments off)
  - upd_ack=0, frame_start=0
  - internal blank mask=4'b0000, slot counter=0, pending flag=0
- Internal state:
  - IDLE (en=0)
  - DEAD (cnt < DEADTIME)
  - ON (cnt ≥ DEADTIME)
  - cnt is a ceil(log2(PRESCALE))-bit slot counter, 0..PRESCALE-1.
  - dig is a 2-bit digit index that wraps 3→0.
- IDLE:
  - an_n=1111, dig=0, cnt=0.
  - A pending or asserted upd_req loads on the next edge, with an upd_ack pulse.
  - Goes to DEAD for digit 0 on the first edge with en=1. frame_start pulses in that first cycle.
- DEAD → ON when cnt reaches DEADTIME.
- ON → DEAD when cnt reaches PRESCALE-1. On that edge cnt←0 and dig←dig+1.
- In ON, an_n[dig]=0 unless the latched blank bit for dig is 1; all other anode bits are 1.
- {s1,s0} changes only at slot start, with anodes already off.
- Update handshake:
  - upd_req sets the pending flag on any edge.
  - The frame boundary is the edge where dig goes 3→0.
  - At that edge, if pending=1 or upd_req=1, mux_a..d←seg_in_a..d and the blank mask←blank_in.
  - upd_ack=1 in the same cycle frame_start=1, and pending is cleared.
  - Data is sampled at the boundary edge, not at request time.
  - If upd_req is held high, the block reloads and acks every frame.
- en falling mid-slot: next cycle goes to IDLE, an_n=1111, dig/cnt=0. Shadows are retained.
- rst mid-operation: all reset values apply the next cycle, and any pending request is dropped.

## Timing

- Slot length is exactly PRESCALE cycles, and a frame is 4·PRESCALE cycles.
- With slot start at cycle T, an_n is low over cycles T+DEADTIME … T+PRESCALE-1. That is PRESCALE-DEADTIME cycles lit per slot.
- Update latency from the upd_req edge to new mux_* data is 1 to 4·PRESCALE cycles while scanning, and 1 cycle in IDLE.
- upd_ack and frame_start are single-cycle pulses, never stretched.
- upd_req and en are sampled on the same edge. If upd_req arrives in the same cycle en rises, it loads at the next frame boundary.

## Test plan

Benches run with PRESCALE=8 and DEADTIME=2.

1. Reset, then en=1 → frame_start at cycle 0; {s1,s0} steps 00,01,10,11 every 8 cycles; an_n equals 1110 during cycles 2–7, 1101 during 10–15, 1011 during 18–23, 0111 during 26–31, and 1111 otherwise. frame_start pulses again at cycle 32.
2. Handshake while scanning:
   - Stimulus: upd_req pulsed at cycle 5 with seg_in_a=7'h40 and seg_in_c=7'h79.
   - Response: mux_* are unchanged until cycle 32. At cycle 32 mux_a=7'h40, mux_c=7'h79, and upd_ack=1 for one cycle, coincident with frame_start.
3. Blanking: load blank_in=4'b0100 → during the frame after the boundary, an_n stays 1111 for all of slot 2; other digits light normally.
4. Handshake while idle:
   - With en=0: upd_req pulse → upd_ack the next cycle, mux_* updated, and an_n stays 1111.
   - With en=0 held: the counters stay at 0.
5. en dropped at cycle 12, mid-ON of digit 1 → cycle 13 has an_n=1111 and s=00. Re-assert en → frame_start and a full slot 0 follow.
6. rst asserted mid-frame with an update pending → next cycle all reset values, mux_*=7'h7F; no upd_ack occurs at the following boundary unless upd_req is reissued.
